conv1_seq_ctrl: RTL and testbench

//   Sequencer for the conv1 stage: loads per-channel 7x7 kernels into NUM_CH conv calc units from a host

---
 rtl/conv1_pkg.sv | 20 ++
 rtl/conv1_tap_counter.sv | 42 ++++
 rtl/conv1_seq_ctrl.sv | 173 +++++++++++++++++
 tb/tb_conv1_seq_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv1_pkg.sv
// Shared types and default geometry for the conv1 sequencer.
// Derived sizes follow the default 28x28 image, 7x7 kernel, 3-channel configuration.
package conv1_pkg;

    localparam int unsigned DEF_WIDTH       = 28;
    localparam int unsigned DEF_HEIGHT      = 28;
    localparam int unsigned DEF_DATA_BITS   = 8;
    localparam int unsigned DEF_FILTER_SIZE = 7;
    localparam int unsigned DEF_NUM_CH      = 3;

    localparam int unsigned TAPS    = DEF_FILTER_SIZE * DEF_FILTER_SIZE;
    localparam int unsigned OUT_DIM = DEF_WIDTH - DEF_FILTER_SIZE + 1;
    localparam int unsigned OUT_PIX = OUT_DIM * (DEF_HEIGHT - DEF_FILTER_SIZE + 1);
    localparam int unsigned IMG_PIX = DEF_WIDTH * DEF_HEIGHT;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} conv1_seq_state_t;

    typedef logic signed [DEF_DATA_BITS-1:0] weight_t;

endpackage

// File: rtl/conv1_tap_counter.sv
// Nested tap/channel write pointer for kernel loading.
// Taps advance on inc and wrap into the next channel; last flags the final word of the load.
module conv1_tap_counter #(
    parameter int unsigned TAPS   = 49,
    parameter int unsigned NUM_CH = 3,
    parameter int unsigned CH_W   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            inc,
    output logic [5:0]      tap,
    output logic [CH_W-1:0] ch,
    output logic            last
);

    logic [5:0]      tap_q;
    logic [CH_W-1:0] ch_q;
    logic            tap_last;
    logic            ch_last;

    assign tap_last = (tap_q == 6'(TAPS - 1));
    assign ch_last  = (ch_q == CH_W'(NUM_CH - 1));
    assign last     = tap_last & ch_last;
    assign tap      = tap_q;
    assign ch       = ch_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            tap_q <= '0;
            ch_q  <= '0;
        end else if (inc) begin
            if (tap_last) begin
                tap_q <= '0;
                ch_q  <= ch_last ? '0 : ch_q + 1'b1;
            end else begin
                tap_q <= tap_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv1_seq_ctrl.sv
// conv1 sequencer: kernel load from the host stream, single-frame pixel admission, output counting.
// Optional weight checksum enabled by defining CONV1_SEQ_CKSUM_EN.
module conv1_seq_ctrl
    import conv1_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned HEIGHT      = DEF_HEIGHT,
    parameter int unsigned DATA_BITS   = DEF_DATA_BITS,
    parameter int unsigned FILTER_SIZE = DEF_FILTER_SIZE,
    parameter int unsigned NUM_CH      = DEF_NUM_CH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 load_w,
    input  logic                 w_valid,
    input  logic [DATA_BITS-1:0] w_data,
    output logic                 w_ready,
    output logic [NUM_CH-1:0]    calc_weight_en,
    output logic [5:0]           calc_weight_addr,
    output logic [DATA_BITS-1:0] calc_weight_in,
    input  logic                 pix_valid_in,
    input  logic [DATA_BITS-1:0] pix_data_in,
    output logic                 pix_ready_out,
    output logic                 conv_valid_in,
    output logic [DATA_BITS-1:0] conv_data_in,
    input  logic                 conv_ready,
    input  logic                 conv_valid_out,
`ifdef CONV1_SEQ_CKSUM_EN
    input  logic [15:0]          cksum_exp,
    output logic                 cksum_err,
`endif
    output logic                 busy,
    output logic                 frame_done
);

    localparam int unsigned NTAPS    = FILTER_SIZE * FILTER_SIZE;
    localparam int unsigned NOUT_PIX = (WIDTH - FILTER_SIZE + 1) * (HEIGHT - FILTER_SIZE + 1);
    localparam int unsigned NIMG_PIX = WIDTH * HEIGHT;
    localparam int unsigned PIX_W    = $clog2(NIMG_PIX + 1);
    localparam int unsigned OUT_W    = $clog2(NOUT_PIX + 1);
    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    conv1_seq_state_t     state_q, state_d;
    logic [PIX_W-1:0]     pix_cnt_q, pix_cnt_d;
    logic [OUT_W-1:0]     out_cnt_q, out_cnt_d;
    logic [NUM_CH-1:0]    en_q, en_d;
    logic [5:0]           addr_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 frame_done_q, frame_done_d;

    logic            run;
    logic            start_ok;
    logic            w_fire;
    logic            pix_fire;
    logic            out_inc;
    logic [5:0]      tap;
    logic [CH_W-1:0] ch;
    logic            last_word;

    assign run      = (state_q == RUN);
    assign start_ok = start && (state_q == IDLE);
    assign w_fire   = w_valid && w_ready;
    assign pix_fire = pix_valid_in && pix_ready_out;
    assign out_inc  = conv_valid_out && ((state_q == RUN) || (state_q == DRAIN));

    assign w_ready          = (state_q == LOAD);
    assign busy             = (state_q != IDLE);
    assign pix_ready_out    = conv_ready && run;
    assign conv_valid_in    = pix_valid_in && run;
    assign conv_data_in     = pix_data_in;
    assign calc_weight_en   = en_q;
    assign calc_weight_addr = addr_q;
    assign calc_weight_in   = data_q;
    assign frame_done       = frame_done_q;

    conv1_tap_counter #(
        .TAPS   (NTAPS),
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_tap_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start_ok),
        .inc   (w_fire),
        .tap   (tap),
        .ch    (ch),
        .last  (last_word)
    );

    always_comb begin
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        out_cnt_d    = out_cnt_q;
        en_d         = '0;
        frame_done_d = 1'b0;
        if (pix_fire) pix_cnt_d = pix_cnt_q + 1'b1;
        if (out_inc)  out_cnt_d = out_cnt_q + 1'b1;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = load_w ? LOAD : RUN;
                    pix_cnt_d = '0;
                    out_cnt_d = '0;
                end
            end
            LOAD: begin
                if (w_fire) begin
                    en_d[ch] = 1'b1;
                    if (last_word) state_d = RUN;
                end
            end
            RUN: begin
                if (pix_fire && (pix_cnt_q == PIX_W'(NIMG_PIX - 1))) state_d = DRAIN;
            end
            DRAIN: begin
                // >= also covers a frame whose outputs all arrived before the last pixel
                if (out_cnt_d >= OUT_W'(NOUT_PIX)) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                    pix_cnt_d    = '0;
                    out_cnt_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pix_cnt_q    <= '0;
            out_cnt_q    <= '0;
            en_q         <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_cnt_q    <= pix_cnt_d;
            out_cnt_q    <= out_cnt_d;
            en_q         <= en_d;
            frame_done_q <= frame_done_d;
            if (w_fire) begin
                addr_q <= tap;
                data_q <= w_data;
            end
        end
    end

`ifdef CONV1_SEQ_CKSUM_EN
    logic [15:0] sum_q;
    logic [15:0] sum_nxt;
    logic        err_q;

    assign sum_nxt   = sum_q + 16'($signed(w_data));
    assign cksum_err = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else if (start_ok) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else if (w_fire) begin
            sum_q <= sum_nxt;
            if (last_word) err_q <= (sum_nxt != cksum_exp);
        end
    end
`endif

endmodule

// File: tb/tb_conv1_seq_ctrl.sv
// Randomized self-checking bench for conv1_seq_ctrl against a count-based behavioural model.
// Define CONV1_SEQ_CKSUM_EN here too when building the checksum variant.
module tb_conv1_seq_ctrl;

    localparam int TAPS = 49;
    localparam int NW   = 147;
    localparam int IMG  = 784;
    localparam int OUTP = 484;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       load_w = 1'b0;
    logic       w_valid = 1'b0;
    logic [7:0] w_data = '0;
    logic       w_ready;
    logic [2:0] calc_weight_en;
    logic [5:0] calc_weight_addr;
    logic [7:0] calc_weight_in;
    logic       pix_valid_in = 1'b0;
    logic [7:0] pix_data_in = '0;
    logic       pix_ready_out;
    logic       conv_valid_in;
    logic [7:0] conv_data_in;
    logic       conv_ready = 1'b0;
    logic       conv_valid_out = 1'b0;
    logic       busy;
    logic       frame_done;
`ifdef CONV1_SEQ_CKSUM_EN
    logic [15:0] cksum_exp = '0;
    logic        cksum_err;
`endif

    always #5 clk = ~clk;

    conv1_seq_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .load_w           (load_w),
        .w_valid          (w_valid),
        .w_data           (w_data),
        .w_ready          (w_ready),
        .calc_weight_en   (calc_weight_en),
        .calc_weight_addr (calc_weight_addr),
        .calc_weight_in   (calc_weight_in),
        .pix_valid_in     (pix_valid_in),
        .pix_data_in      (pix_data_in),
        .pix_ready_out    (pix_ready_out),
        .conv_valid_in    (conv_valid_in),
        .conv_data_in     (conv_data_in),
        .conv_ready       (conv_ready),
        .conv_valid_out   (conv_valid_out),
`ifdef CONV1_SEQ_CKSUM_EN
        .cksum_exp        (cksum_exp),
        .cksum_err        (cksum_err),
`endif
        .busy             (busy),
        .frame_done       (frame_done)
    );

    int checks = 0;
    int failures = 0;

    function automatic void check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Model: phase 0 idle, 1 loading, 2 admitting pixels, 3 waiting for outputs
    int       m_phase = 0;
    int       m_words = 0;
    int       m_pix = 0;
    int       m_outs = 0;
    int       m_sum = 0;
    bit       m_err = 1'b0;
    bit       m_on = 1'b0;
    bit       m_done = 1'b0;
    int       m_en = 0;
    int       m_addr = 0;
    int       m_data = 0;

    int       en_pulses = 0;
    int       cap_idx = 49;
    int       cap_en = 0;
    int       cap_addr = 0;
    int       cap_data = 0;
    int       pix_passed = 0;

    always @(negedge clk) begin
        if (m_on) begin
            check("busy", int'(busy), int'(m_phase != 0));
            check("w_ready", int'(w_ready), int'(m_phase == 1));
            check("pix_ready_out", int'(pix_ready_out), int'(conv_ready && m_phase == 2));
            check("conv_valid_in", int'(conv_valid_in), int'(pix_valid_in && m_phase == 2));
            check("frame_done", int'(frame_done), int'(m_done));
            check("calc_weight_en", int'(calc_weight_en), m_en);
            if (m_en != 0) begin
                check("calc_weight_addr", int'(calc_weight_addr), m_addr);
                check("calc_weight_in", int'(calc_weight_in), m_data);
            end
`ifdef CONV1_SEQ_CKSUM_EN
            check("cksum_err", int'(cksum_err), int'(m_err));
`endif
            if (conv_valid_in && pix_ready_out) begin
                check("pix_order", int'(conv_data_in), pix_passed & 255);
                pix_passed++;
            end
        end
        if (calc_weight_en != 0) begin
            if (en_pulses == cap_idx) begin
                cap_en   = int'(calc_weight_en);
                cap_addr = int'(calc_weight_addr);
                cap_data = int'(calc_weight_in);
            end
            en_pulses++;
        end

        // Next-cycle expectations from the inputs that the coming edge will sample
        m_en = 0;
        m_done = 1'b0;
        if (!rst_n) begin
            m_phase = 0;
            m_words = 0;
            m_sum = 0;
            m_err = 1'b0;
            m_on = 1'b1;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = load_w ? 1 : 2;
                    m_words = 0;
                    m_pix = 0;
                    m_outs = 0;
                    m_sum = 0;
                    m_err = 1'b0;
                end
                1: if (w_valid) begin
                    m_en = 1 << (m_words / TAPS);
                    m_addr = m_words % TAPS;
                    m_data = int'(w_data);
                    m_sum += int'($signed(w_data));
                    m_words++;
                    if (m_words == NW) begin
                        m_phase = 2;
`ifdef CONV1_SEQ_CKSUM_EN
                        m_err = ((m_sum & 16'hffff) != int'(cksum_exp));
`endif
                    end
                end
                2: begin
                    if (conv_valid_out) m_outs++;
                    if (pix_valid_in && conv_ready) begin
                        m_pix++;
                        if (m_pix == IMG) m_phase = 3;
                    end
                end
                default: begin
                    if (conv_valid_out) m_outs++;
                    if (m_outs >= OUTP) begin
                        m_phase = 0;
                        m_done = 1'b1;
                    end
                end
            endcase
        end
    end

    int drv_total = 0;
    int outs_sent = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int n);
        int i;
        int cyc;
        start = 1'b1;
        load_w = 1'b1;
        tick();
        start = 1'b0;
        i = 0;
        cyc = 0;
        while (i < n && cyc < 2000) begin
            w_valid = (cyc % 5 != 4);
            w_data = 8'(i - 73);
            conv_valid_out = 1'($urandom_range(0, 1));
            conv_ready = 1'($urandom_range(0, 1));
            pix_valid_in = 1'($urandom_range(0, 1));
            pix_data_in = 8'($urandom);
            load_w = 1'($urandom_range(0, 1));
            tick();
            if (w_valid) i++;
            cyc++;
        end
        w_valid = 1'b0;
        conv_valid_out = 1'b0;
        pix_valid_in = 1'b0;
        if (i < n) check("load_budget", i, n);
    endtask

    task automatic run_frame();
        int base;
        int cyc;
        base = pix_passed;
        outs_sent = 0;
        cyc = 0;
        while (drv_total - base < IMG && cyc < 20000) begin
            conv_ready = (cyc % 2 == 0);
            pix_valid_in = ($urandom_range(0, 3) != 0);
            pix_data_in = 8'(drv_total);
            conv_valid_out = (outs_sent < OUTP - 1) && ($urandom_range(0, 1) == 1);
            start = ($urandom_range(0, 7) == 0);
            load_w = 1'($urandom_range(0, 1));
            #1;
            if (conv_valid_out) outs_sent++;
            if (pix_valid_in && pix_ready_out) drv_total++;
            tick();
            cyc++;
        end
        if (drv_total - base < IMG) check("pixel_budget", drv_total - base, IMG);
        start = 1'b0;
        conv_valid_out = 1'b0;
        pix_valid_in = 1'b1;
        conv_ready = 1'b1;
        #1;
        check("ready_after_last", int'(pix_ready_out), 0);
        check("pixels_passed", pix_passed - base, IMG);
        while (outs_sent < OUTP - 1) begin
            conv_valid_out = 1'b1;
            tick();
            outs_sent++;
        end
        conv_valid_out = 1'b0;
        repeat (9) tick();
        check("busy_before_last_out", int'(busy), 1);
        conv_valid_out = 1'b1;
        tick();
        conv_valid_out = 1'b0;
        pix_valid_in = 1'b0;
        check("frame_done_pulse", int'(frame_done), 1);
        check("busy_drop", int'(busy), 0);
        tick();
        check("frame_done_single", int'(frame_done), 0);
        check("idle_after_frame", int'(busy), 0);
    endtask

    initial begin
        int e0;
        conv_ready = 1'b1;
        pix_valid_in = 1'b1;
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_w_ready", int'(w_ready), 0);
        check("rst_en", int'(calc_weight_en), 0);
        check("rst_pix_ready", int'(pix_ready_out), 0);
        check("rst_conv_valid", int'(conv_valid_in), 0);
        check("rst_frame_done", int'(frame_done), 0);
        rst_n = 1'b1;
        pix_valid_in = 1'b0;
        conv_ready = 1'b0;
        tick();

        // Kernel load with gaps
        en_pulses = 0;
        cap_idx = 49;
        do_load(NW);
        conv_ready = 1'b1;
        #1;
        check("run_after_load_wready", int'(w_ready), 0);
        check("run_after_load_busy", int'(busy), 1);
        check("run_after_load_pixready", int'(pix_ready_out), 1);
        tick();
        check("en_pulse_count", en_pulses, NW);
        check("word49_en", cap_en, 2);
        check("word49_addr", cap_addr, 0);
        check("word49_data", cap_data, 232);
`ifdef CONV1_SEQ_CKSUM_EN
        check("cksum_ok", int'(cksum_err), 0);
`endif
        run_frame();

        // Reuse loaded kernels
        e0 = en_pulses;
        start = 1'b1;
        load_w = 1'b0;
        tick();
        start = 1'b0;
        conv_ready = 1'b1;
        #1;
        check("reuse_run_busy", int'(busy), 1);
        check("reuse_run_ready", int'(pix_ready_out), 1);
        run_frame();
        check("reuse_no_en", en_pulses, e0);

        // Abort mid-load, then a full reload
        do_load(60);
        rst_n = 1'b0;
        conv_ready = 1'b1;
        pix_valid_in = 1'b1;
        tick();
        check("abort_busy", int'(busy), 0);
        check("abort_w_ready", int'(w_ready), 0);
        check("abort_en", int'(calc_weight_en), 0);
        check("abort_addr", int'(calc_weight_addr), 0);
        check("abort_data", int'(calc_weight_in), 0);
        check("abort_pix_ready", int'(pix_ready_out), 0);
        check("abort_conv_valid", int'(conv_valid_in), 0);
        check("abort_frame_done", int'(frame_done), 0);
        rst_n = 1'b1;
        pix_valid_in = 1'b0;
        tick();
        cap_idx = en_pulses;
`ifdef CONV1_SEQ_CKSUM_EN
        cksum_exp = 16'd1;
`endif
        do_load(NW);
        tick();
        check("reload_first_en", cap_en, 1);
        check("reload_first_addr", cap_addr, 0);
        check("reload_first_data", cap_data, 183);
`ifdef CONV1_SEQ_CKSUM_EN
        check("cksum_bad", int'(cksum_err), 1);
`endif
        run_frame();
`ifdef CONV1_SEQ_CKSUM_EN
        check("cksum_sticky", int'(cksum_err), 1);
        start = 1'b1;
        load_w = 1'b0;
        tick();
        start = 1'b0;
        check("cksum_cleared", int'(cksum_err), 0);
        run_frame();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
